// File: rtl/stream_mux4.sv
// stream_mux4: merges four valid/ready producer channels onto a single
// registered output stream. Each output word is tagged with its source
// channel index so a downstream demultiplexer can route it back out.
//
// Arbitration is round-robin (lock=0) or pinned to channel `select` (lock=1).
// The output is a one-entry register that reloads in the same cycle it is
// drained, which gives one word per cycle while out_ready stays high.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_data0..in_data3      per-channel data
//   in_valid[3:0]           per-channel word available
//   in_ready[3:0]           per-channel word accepted this cycle (one-hot or 0)
//   lock, select            pin arbitration to channel `select` when lock=1
//   out_data, out_sel       registered word and its source channel
//   out_valid, out_ready    output handshake
//   xfer_count              completed output handshakes, wraps at 2^CNT_W
module stream_mux4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic             lock,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  logic [1:0]       ptr;
  logic             load;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic [3:0]       grant;
  logic [WIDTH-1:0] grant_data;
  logic             out_xfer;

  // The output register can accept a new word when it is empty or being
  // drained this very cycle.
  assign load     = !out_valid || out_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    grant     = 4'b0000;
    if (load && !reset) begin
      if (lock) begin
        if (in_valid[select]) begin
          grant_any = 1'b1;
          grant_idx = select;
        end
      end else begin
        // Scan ptr, ptr+1, ... with natural 2-bit wrap; first valid wins.
        for (int k = 0; k < 4; k++) begin
          cand = ptr + 2'(k);
          if (!grant_any && in_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign in_ready = grant;

  always_comb begin
    grant_data = in_data0;
    case (grant_idx)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'd0;
      xfer_count <= '0;
      ptr        <= 2'd0;
    end else begin
      if (out_xfer) begin
        xfer_count <= xfer_count + CNT_W'(1);
      end
      if (grant_any) begin
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        out_valid <= 1'b1;
        // A pinned transfer must not disturb the round-robin position.
        if (!lock) begin
          ptr <= grant_idx + 2'd1;
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux4.sv
// Self-checking bench for stream_mux4. A second instance with CNT_W=2 shares
// all inputs so counter wrap is observed alongside the main instance.
module tb_stream_mux4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_valid;
  logic       lock;
  logic [1:0] select;
  logic       out_ready;

  logic [3:0] in_ready, in_ready2;
  logic [3:0] out_data, out_data2;
  logic [1:0] out_sel, out_sel2;
  logic       out_valid, out_valid2;
  logic [7:0] xfer_count;
  logic [1:0] xfer_count2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: output register contents, pointer, transfer count.
  bit m_v;
  int m_data, m_sel, m_ptr, m_cnt;

  always #5 clk = ~clk;

  stream_mux4 #(.WIDTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_valid(in_valid), .in_ready(in_ready),
    .lock(lock), .select(select),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  stream_mux4 #(.WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_valid(in_valid), .in_ready(in_ready2),
    .lock(lock), .select(select),
    .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2),
    .out_ready(out_ready), .xfer_count(xfer_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int chan_data(int c);
    case (c)
      0:       return int'(in_data0);
      1:       return int'(in_data1);
      2:       return int'(in_data2);
      default: return int'(in_data3);
    endcase
  endfunction

  // Which channel should win this cycle, or -1 for none.
  function automatic int exp_grant();
    int c;
    if (reset) return -1;
    if (m_v && !out_ready) return -1;
    if (lock) return in_valid[select] ? int'(select) : -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready mid-cycle, advance the model, check outputs.
  task automatic cycle();
    int g;
    int exp_rdy;
    int gdata;
    @(negedge clk);
    g = exp_grant();
    exp_rdy = (g < 0) ? 0 : (1 << g);
    gdata = (g < 0) ? 0 : chan_data(g);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("in_ready_w2", 32'(in_ready2), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (reset) begin
      m_v = 0; m_data = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      if (m_v && out_ready) m_cnt++;
      if (g >= 0) begin
        m_v = 1; m_data = gdata; m_sel = g;
        if (!lock) m_ptr = (g + 1) % 4;
      end else if (m_v && out_ready) begin
        m_v = 0;
      end
    end
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt % 256));
    chk("xfer_count_w2", 32'(xfer_count2), 32'(m_cnt % 4));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    m_v = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    reset = 1'b1;
    in_data0 = 4'h0; in_data1 = 4'h0; in_data2 = 4'h0; in_data3 = 4'h0;
    in_valid = 4'b0000; lock = 1'b0; select = 2'd0; out_ready = 1'b1;

    // Reset state with nothing valid.
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);

    // Round-robin over all four channels at full throughput.
    in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(10 + i % 4));
    end
    in_valid = 4'b0000;
    cycle();
    chk("rr_count5", 32'(xfer_count), 32'd5);
    cycle();

    // Locked to channel 2, then unlock: pointer untouched, so ch0 next.
    do_reset();
    lock = 1'b1; select = 2'd2; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("lock_sel", 32'(out_sel), 32'd2);
    end
    lock = 1'b0;
    cycle();
    chk("unlock_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b0000;
    cycle();

    // Stall with a word from ch1, then release; ch2 wins over ch1 afterwards.
    in_data1 = 4'h5; in_valid = 4'b0010; out_ready = 1'b1;
    cycle();
    in_valid = 4'b0110; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_data", 32'(out_data), 32'h5);
      chk("stall_sel", 32'(out_sel), 32'd1);
    end
    out_ready = 1'b1;
    cycle();
    chk("post_stall_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0000;
    cycle();

    // Reset right after capturing from ch3 drops the word; ch3 re-granted.
    in_data3 = 4'h7; in_valid = 4'b1000;
    cycle();
    reset = 1'b1;
    cycle();
    chk("drop_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    cycle();
    chk("regrant_data", 32'(out_data), 32'h7);
    chk("regrant_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b0000;
    cycle();
    chk("regrant_once", 32'(out_valid), 32'd0);

    // Narrow counter wraps: 1,2,3,0,1.
    do_reset();
    in_valid = 4'b1111;
    cycle();
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("wrap_cnt", 32'(xfer_count2), 32'(i % 4));
    end
    in_valid = 4'b0000;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      in_data0  = 4'($urandom);
      in_data1  = 4'($urandom);
      in_data2  = 4'($urandom);
      in_data3  = 4'($urandom);
      lock      = ($urandom_range(0, 3) == 0);
      select    = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux4.md
Name: stream_mux4

Overview:
- Gathering counterpart of the 1-to-4 demultiplexer: merges four 4-bit producer channels onto one output stream.
- Each input channel uses a valid/ready handshake; the output is a one-entry registered stage with its own valid/ready handshake.
- Arbitration is either round-robin across all channels or locked to one channel chosen by a 2-bit select.
- Every output word carries the index of its source channel, so a downstream demultiplexer can route it back out.

Parameters:
- WIDTH, 4, data width of every channel.
- CNT_W, 8, width of the output transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data0..in_data3  input  WIDTH each  channel data.
- in_valid  input  4  bit i: channel i holds a word.
- in_ready  output  4  bit i: channel i word accepted this cycle.
- lock  input  1  1 = serve only channel `select`; 0 = round-robin.
- select  input  2  channel index used when lock=1.
- out_data  output  WIDTH  registered output word.
- out_sel  output  2  source channel index of out_data.
- out_valid  output  1  out_data/out_sel are valid.
- out_ready  input  1  downstream accepts the word.
- xfer_count  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset, synchronous and active-high, sampled on a clk edge:
  - out_valid=0, out_data=0, out_sel=0, xfer_count=0, round-robin pointer=0.
  - in_ready=0 while reset is high.
  - A word held in the output register is discarded; nothing completes that cycle.
- Load enable: load = !out_valid || out_ready. Throughput is 1 word/cycle, with no bubble when out_ready stays high.
- Grant, combinational, one-hot or zero:
  - Only computed when load=1 and reset=0; otherwise grant=0.
  - lock=1: grant[select] = in_valid[select]; all other channels see in_ready=0.
  - lock=0: the first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod 4.
  - in_ready = grant.
- Handshake and latency:
  - An input transfer occurs when in_valid[i] && in_ready[i].
  - On the next edge: out_data = in_data[i], out_sel = i, out_valid = 1. Latency is 1 cycle.
- Output transfer occurs when out_valid && out_ready.
  - If a grant happens in the same cycle, the register reloads and out_valid stays 1.
  - Otherwise out_valid clears.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sel hold stable, and in_ready=0 on all channels.
- Pointer:
  - Updates only on an input transfer with lock=0: ptr = (i+1) mod 4.
  - A transfer under lock=1 leaves ptr unchanged.
- Fairness: with all four channels continuously valid and lock=0, the grant order is 0,1,2,3,0,... Each channel waits at most 3 grants.
- lock/select changes affect only the next grant decision. A word already in the output register is unaffected.
- xfer_count increments by 1 on each output transfer and wraps modulo 2^CNT_W without saturating.
- No words are dropped or duplicated. Every input transfer produces exactly one output transfer unless reset intervenes.
- Upstream must hold in_data stable while in_valid=1 and its in_ready=0. The block does not check this.

Test Plan:
- Reset, then in_valid=4'b0000 -> out_valid=0, in_ready=0, xfer_count=0.
- lock=0, all valid, data ch0..3 = 4'hA,4'hB,4'hC,4'hD, out_ready=1 -> one word per cycle, 1 cycle after grant. out_sel sequence 0,1,2,3,0; out_data A,B,C,D,A; xfer_count=5 after five words.
- lock=1, select=2, all valid -> only ch2 is granted, out_sel=2 every cycle, in_ready=4'b0100. Then lock=0 -> the next grant goes to ch0, since ptr is still 0.
- Capture 4'h5 from ch1, hold out_ready=0 for 4 cycles -> out_data=5 and out_sel=1 stable, in_ready=0. Release -> word consumed once, then ch2 granted next.
- Only ch3 valid (4'h7), out_ready=1, reset asserted in the cycle after capture -> word dropped, out_valid=0, ptr=0. After reset, ch3 is re-granted and 4'h7 appears once.
- CNT_W=2, perform 5 output transfers -> xfer_count sequence 1,2,3,0,1.
